// File: rtl/demux3_pkg.sv
// rtl/demux3_pkg.sv - shared constants and target decode for demux3_buf
//
// Purpose: selector encodings, default data width, counter width/limit and
// the selector-to-channel decode used by the steering block.
// Ports: none (package).
package demux3_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [2:0] SEL_CH0 = 3'b000;
  localparam logic [2:0] SEL_CH1 = 3'b001;
  localparam logic [2:0] SEL_CH2 = 3'b010;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Any code outside 0..2 falls back to channel 0, matching the selector muxes.
  function automatic logic [1:0] eff_target(input logic [2:0] sel);
    logic [1:0] t;
    case (sel)
      SEL_CH1: t = 2'd1;
      SEL_CH2: t = 2'd2;
      default: t = 2'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/demux3_slot.sv
// rtl/demux3_slot.sv - one-entry output buffer with load/drain control
//
// Purpose: holds one word for a single destination channel.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load           write din into the buffer this cycle
//   out_ready      consumer takes the held word this cycle
//   din            word to capture on load
//   valid          buffer holds a word
//   dout           buffer contents (last value held when empty)
module demux3_slot
  import demux3_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load wins over drain so a simultaneous drain+load keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/demux3_buf.sv
// rtl/demux3_buf.sv - 1-to-3 steering block with per-channel one-entry buffers
//
// Purpose: routes one word per cycle to channel 0/1/2 chosen by selector;
// each channel has its own valid/ready handshake so a stalled consumer only
// blocks words headed to it. Illegal selector codes go to channel 0 and raise
// a registered one-cycle sel_err pulse.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        producer handshake (in_ready combinational)
//   selector, data_in          destination code and word
//   out_valid[2:0], out_ready  per-channel consumer handshake
//   data_out_0..2              channel buffer contents
//   sel_err                    pulse after accepting an illegal selector
//   cnt_0..2                   accepted-word counters (DEMUX3_COUNT_EN only)
// Configuration: define DEMUX3_COUNT_EN to add saturating per-channel counters.
module demux3_buf
  import demux3_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        selector,
  input  logic [DATA_W-1:0] data_in,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
`ifdef DEMUX3_COUNT_EN
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
`endif
  output logic              sel_err
);

  logic [1:0] target;
  logic       accept;
  logic [2:0] load;
  logic       sel_err_q, sel_err_d;

  assign target = eff_target(selector);

  // Ready if the target slot is empty or being drained this cycle.
  always_comb begin
    case (target)
      2'd1:    in_ready = ~out_valid[1] | out_ready[1];
      2'd2:    in_ready = ~out_valid[2] | out_ready[2];
      default: in_ready = ~out_valid[0] | out_ready[0];
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = 3'b000;
    case (target)
      2'd1:    load[1] = accept;
      2'd2:    load[2] = accept;
      default: load[0] = accept;
    endcase
  end

  demux3_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .reset(reset), .load(load[0]), .out_ready(out_ready[0]),
    .din(data_in), .valid(out_valid[0]), .dout(data_out_0)
  );

  demux3_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .reset(reset), .load(load[1]), .out_ready(out_ready[1]),
    .din(data_in), .valid(out_valid[1]), .dout(data_out_1)
  );

  demux3_slot #(.DATA_W(DATA_W)) u_slot2 (
    .clk(clk), .reset(reset), .load(load[2]), .out_ready(out_ready[2]),
    .din(data_in), .valid(out_valid[2]), .dout(data_out_2)
  );

  assign sel_err_d = accept & (selector > SEL_CH2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef DEMUX3_COUNT_EN
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // Counts follow the effective channel, so illegal codes land in cnt_0.
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      cnt_d[n] = cnt_q[n];
      if (load[n] && (cnt_q[n] != CNT_MAX)) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 3; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign cnt_0 = cnt_q[0];
  assign cnt_1 = cnt_q[1];
  assign cnt_2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_demux3_buf.sv
// tb/tb_demux3_buf.sv - directed self-checking bench for demux3_buf
module tb_demux3_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2;
  logic        sel_err;
`ifdef DEMUX3_COUNT_EN
  logic [15:0] cnt_0, cnt_1, cnt_2;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  demux3_buf #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
`ifdef DEMUX3_COUNT_EN
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2),
`endif
    .sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    selector  = 3'b000;
    data_in   = '0;
    out_ready = 3'b000;
    tick();
    tick();
    chk("rst_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_d0", data_out_0, 32'd0);
    chk("rst_d1", data_out_1, 32'd0);
    chk("rst_d2", data_out_2, 32'd0);
    chk("rst_err", {31'd0, sel_err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // Single word to ch0, consumer not ready.
    selector = 3'b000; data_in = 32'hDEADBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", {29'd0, out_valid}, 32'h1);
    chk("t1_d0", data_out_0, 32'hDEADBEEF);
    chk("t1_err", {31'd0, sel_err}, 32'd0);
    selector = 3'b000; #1;
    chk("t1_rdy_ch0", {31'd0, in_ready}, 32'd0);
    selector = 3'b001; #1;
    chk("t1_rdy_ch1", {31'd0, in_ready}, 32'd1);

    // Fill ch1, then stall a second word until the consumer is ready.
    selector = 3'b001; data_in = 32'h11; in_valid = 1'b1;
    tick();
    chk("t2_fill", data_out_1, 32'h11);
    data_in = 32'h22; #1;
    chk("t2_stall_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t2_hold", data_out_1, 32'h11);
    out_ready = 3'b010; #1;
    chk("t2_rdy_up", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    chk("t2_d1", data_out_1, 32'h22);
    chk("t2_v1", {31'd0, out_valid[1]}, 32'd1);

    // Full-throughput stream into ch2.
    out_ready = 3'b100; selector = 3'b010; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hA0 + i; #1;
      chk("t3_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("t3_d2", data_out_2, 32'hA0 + i);
      chk("t3_v2", {31'd0, out_valid[2]}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t3_drained", {31'd0, out_valid[2]}, 32'd0);

    // Drain ch0 and ch1 together.
    out_ready = 3'b011;
    tick();
    out_ready = 3'b000;
    chk("drain_all", {29'd0, out_valid}, 32'd0);

    // Illegal selector goes to ch0 and pulses sel_err once.
    selector = 3'b111; data_in = 32'h5; in_valid = 1'b1; #1;
    chk("t4_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_d0", data_out_0, 32'h5);
    chk("t4_v0", {31'd0, out_valid[0]}, 32'd1);
    chk("t4_err", {31'd0, sel_err}, 32'd1);
    tick();
    chk("t4_err_end", {31'd0, sel_err}, 32'd0);
    selector = 3'b111; data_in = 32'h6; in_valid = 1'b1; #1;
    chk("t4_blk_rdy", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("t4_blk_err", {31'd0, sel_err}, 32'd0);
    chk("t4_blk_d0", data_out_0, 32'h5);

    // All channels full, then async reset mid-cycle.
    in_valid = 1'b1;
    selector = 3'b001; data_in = 32'h111;
    tick();
    selector = 3'b010; data_in = 32'h222;
    tick();
    in_valid = 1'b0;
    chk("t5_full", {29'd0, out_valid}, 32'h7);
    #2 reset = 1'b1;
    #1;
    chk("t5_valid", {29'd0, out_valid}, 32'd0);
    chk("t5_d0", data_out_0, 32'd0);
    chk("t5_d1", data_out_1, 32'd0);
    chk("t5_d2", data_out_2, 32'd0);
    chk("t5_err", {31'd0, sel_err}, 32'd0);
`ifdef DEMUX3_COUNT_EN
    chk("t5_cnt0", {16'd0, cnt_0}, 32'd0);
    chk("t5_cnt1", {16'd0, cnt_1}, 32'd0);
    chk("t5_cnt2", {16'd0, cnt_2}, 32'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

`ifdef DEMUX3_COUNT_EN
    // Three legal ch0 words plus one illegal code, all counted on ch0.
    out_ready = 3'b001; in_valid = 1'b1;
    selector = 3'b000;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h100 + i;
      tick();
    end
    selector = 3'b101; data_in = 32'h200;
    tick();
    in_valid = 1'b0;
    chk("c_cnt0", {16'd0, cnt_0}, 32'd4);
    chk("c_cnt1", {16'd0, cnt_1}, 32'd0);
    chk("c_cnt2", {16'd0, cnt_2}, 32'd0);

    // Drive cnt_1 to its limit, then one more accept must not wrap.
    out_ready = 3'b010; selector = 3'b001; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      data_in = i;
      tick();
    end
    chk("c_sat", {16'd0, cnt_1}, 32'h0000FFFF);
    tick();
    in_valid = 1'b0;
    chk("c_sat_hold", {16'd0, cnt_1}, 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/demux3_buf.md
Name: demux3_buf

Overview:
- 1-to-3 steering block, the inverse of the datapath's 3-input selector muxes.
- Takes one 32-bit word with a 3-bit selector and delivers it to one of three destination channels (e.g. ALUOut/HI/LO-style consumers).
- Each channel has a one-entry output buffer and a valid/ready handshake, so a slow consumer stalls only its own traffic.
- Sits between a shared result bus and independent datapath registers in the multicycle core.

Parameters:
- DATA_W, 32, width of data_in and every data_out_N.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word this cycle.
- selector  input  3  destination: 3'b000 ch0, 3'b001 ch1, 3'b010 ch2; any other code is treated as ch0.
- data_in  input  DATA_W  word to route.
- out_valid  output  3  bit N set: channel N buffer holds a word.
- out_ready  input  3  bit N set: consumer N takes the word this cycle.
- data_out_0, data_out_1, data_out_2  output  DATA_W  channel buffer contents.
- sel_err  output  1  one-cycle pulse, registered, after a word with an illegal selector is accepted.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=3'b000, all data_out_N=0, sel_err=0.
  - in_ready is combinational and reads 1 after reset.
- Effective target T:
  - T = selector when selector is 0..2.
  - T = 0 otherwise (same default as the muxes).
- in_ready = ~out_valid[T] | out_ready[T]. Combinational from selector, out_valid and out_ready only; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept at edge k:
  - data_out_T <= data_in and out_valid[T] <= 1, visible at k+1 (latency 1).
  - data_out_T must not change while out_valid[T] is high and the word is not consumed.
- Drain: out_valid[N] & out_ready[N] at edge k clears out_valid[N] at k+1, unless the same edge accepts into N.
  - Simultaneous drain and accept on the same channel: out_valid[N] stays 1 and data is replaced. This gives full throughput of 1 word/cycle per channel.
- Other channels are unaffected by an accept; drains on all three channels may occur in the same cycle.
- Data values of empty channels are don't-care for consumers, but RTL holds the last value (no clearing).
- sel_err <= accept & (selector > 3'b010), so it is high exactly one cycle after an illegal-code accept. No pulse if the word is not accepted.
- Backpressure: in_valid high with in_ready low means nothing changes. The producer holds data_in/selector stable until accepted; the block does not check this.
- Reset mid-transfer: all buffered words are discarded and no partial state survives.

Optional Feature:
- Macro DEMUX3_COUNT_EN.
- Defined:
  - Adds outputs cnt_0, cnt_1, cnt_2, each 16 bits, counting accepted words per effective channel.
  - Counters saturate at 16'hFFFF and are cleared by reset.
  - An illegal-code word counts toward cnt_0.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (demux3_pkg) holds:
  - selector encodings SEL_CH0=3'b000, SEL_CH1=3'b001, SEL_CH2=3'b010;
  - DATA_W default;
  - CNT_W=16 and CNT_MAX constant.
- One sub-module, demux3_slot: one-entry buffer with load/drain inputs and valid/data outputs, instantiated three times. Top level holds target decode, in_ready, sel_err and the optional counters.

Test Plan:
- Reset then sel=000, data=32'hDEADBEEF, in_valid 1 cycle, out_ready=0 -> next cycle out_valid=001, data_out_0=DEADBEEF; in_ready=0 for sel=000, 1 for sel=001.
- Fill ch1 (sel=001, 32'h11) with out_ready[1]=0; offer sel=001, 32'h22 -> stalled (in_ready=0), data_out_1 holds 11; raise out_ready[1] -> accepted same cycle, next cycle data_out_1=22, out_valid[1]=1.
- Stream 4 words to ch2 with out_ready[2]=1 throughout -> one accept per cycle; data_out_2 shows each word exactly one cycle after its accept.
- sel=111, data=32'h5 accepted -> data_out_0=5, out_valid[0]=1, sel_err=1 for exactly one cycle; same word with in_ready low -> no sel_err.
- All three channels full; assert reset for 1 cycle mid-stream -> out_valid=000, data_out_N=0, sel_err=0 immediately (async); with DEMUX3_COUNT_EN, cnt_N=0.
- With DEMUX3_COUNT_EN, accept 3 words to ch0 and 1 illegal-code word -> cnt_0=4, cnt_1=0, cnt_2=0; force cnt_1 to 16'hFFFF then accept to ch1 -> stays FFFF.
